branch_resolve_unit: RTL and testbench

Parametrised branch resolution and prediction unit for the execute stage. It compares full register operands itself rather than relying on an ALU zero flag, and resolves conditional branches, JAL and JALR. It computes the redirect target and flags mispredictions against the fetch-time guess. It also owns a bimodal branch history table (BHT) of saturating counters that feeds the fetch-stage prediction and is trained at resolution.

---
 rtl/branch_resolve_unit.sv | 156 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: evaluates branch conditions, JAL and JALR targets,
// flags mispredictions, and owns the bimodal BHT that drives the fetch-stage guess.
module branch_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic             flush,
  input  logic [1:0]       res_kind,
  input  logic [2:0]       res_funct3,
  input  logic [XLEN-1:0]  res_rs1,
  input  logic [XLEN-1:0]  res_rs2,
  input  logic [XLEN-1:0]  res_pc,
  input  logic [XLEN-1:0]  res_imm,
  input  logic             res_pred_taken,
  output logic             out_valid,
  output logic             out_taken,
  output logic             out_mispredict,
  output logic             out_illegal,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_link,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;

  typedef enum logic [1:0] {
    KIND_BR   = 2'b00,
    KIND_JAL  = 2'b01,
    KIND_JALR = 2'b10,
    KIND_RSVD = 2'b11
  } kind_e;

  kind_e               kind;
  logic                accept;
  logic                cond;
  logic                illegal;
  logic                taken;
  logic                mispredict;
  logic                train;
  logic [XLEN-1:0]     link;
  logic [XLEN-1:0]     target;
  logic [IDX_W-1:0]    res_idx;
  logic [IDX_W-1:0]    pred_idx;
  logic [CTR_BITS-1:0] bht [BHT_ENTRIES];

  assign kind     = kind_e'(res_kind);
  assign accept   = res_valid & ~flush;
  assign link     = res_pc + XLEN'(4);
  assign res_idx  = res_pc[IDX_W+1:2];
  assign pred_idx = pred_pc[IDX_W+1:2];

  // Only the word-aligned index bits of the fetch PC select a counter.
  logic unused_pred_pc_bits;
  assign unused_pred_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

  assign pred_taken = bht[pred_idx][CTR_BITS-1];

  // NOTE: every signal written in a combinational block gets a default first so no latch is inferred.
  always_comb begin
    cond = 1'b0;
    case (res_funct3)
      3'b000:  cond = (res_rs1 == res_rs2);
      3'b001:  cond = (res_rs1 != res_rs2);
      3'b100:  cond = ($signed(res_rs1) <  $signed(res_rs2));
      3'b101:  cond = ($signed(res_rs1) >= $signed(res_rs2));
      3'b110:  cond = (res_rs1 <  res_rs2);
      3'b111:  cond = (res_rs1 >= res_rs2);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    illegal    = 1'b0;
    taken      = 1'b0;
    mispredict = 1'b0;
    target     = link;
    case (kind)
      KIND_BR: begin
        illegal    = (res_funct3[2:1] == 2'b01);
        taken      = cond & ~illegal;
        mispredict = ~illegal & (taken != res_pred_taken);
        target     = taken ? (res_pc + res_imm) : link;
      end
      KIND_JAL: begin
        taken      = 1'b1;
        mispredict = ~res_pred_taken;
        target     = res_pc + res_imm;
      end
      KIND_JALR: begin
        taken      = 1'b1;
        mispredict = 1'b1;
        target     = (res_rs1 + res_imm) & ~XLEN'(1);
      end
      default: illegal = 1'b1;
    endcase
  end

  assign train = accept & (kind == KIND_BR) & ~illegal;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_mispredict <= 1'b0;
      out_illegal    <= 1'b0;
      out_target     <= '0;
      out_link       <= '0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        out_taken      <= taken;
        out_mispredict <= mispredict;
        out_illegal    <= illegal;
        out_target     <= target;
        out_link       <= link;
      end
    end
  end

  // NOTE: the BHT is reset entry by entry because fetch reads it straight after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_INIT;
    end else if (train) begin
      if (taken && bht[res_idx] != CTR_MAX)
        bht[res_idx] <= bht[res_idx] + CTR_BITS'(1);
      else if (!taken && bht[res_idx] != '0)
        bht[res_idx] <= bht[res_idx] - CTR_BITS'(1);
    end
  end

  // Statistics counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (train && branch_count != '1)
        branch_count <= branch_count + CNT_W'(1);
      if (accept && mispredict && mispredict_count != '1)
        mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios then random requests
// compared against a behavioural model of the resolution rules and BHT.
module tb_branch_resolve_unit;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 64;
  localparam int CNT_W   = 4;
  localparam int CTR_MAX = 3;
  localparam int CNT_MAX = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [XLEN-1:0]  pred_pc = '0;
  logic             pred_taken;
  logic             res_valid = 1'b0;
  logic             flush = 1'b0;
  logic [1:0]       res_kind = '0;
  logic [2:0]       res_funct3 = '0;
  logic [XLEN-1:0]  res_rs1 = '0, res_rs2 = '0, res_pc = '0, res_imm = '0;
  logic             res_pred_taken = 1'b0;
  logic             out_valid, out_taken, out_mispredict, out_illegal;
  logic [XLEN-1:0]  out_target, out_link;
  logic [CNT_W-1:0] branch_count, mispredict_count;

  branch_resolve_unit #(.XLEN(XLEN), .BHT_ENTRIES(ENTRIES), .CTR_BITS(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .res_valid(res_valid), .flush(flush), .res_kind(res_kind), .res_funct3(res_funct3),
    .res_rs1(res_rs1), .res_rs2(res_rs2), .res_pc(res_pc), .res_imm(res_imm),
    .res_pred_taken(res_pred_taken), .out_valid(out_valid), .out_taken(out_taken),
    .out_mispredict(out_mispredict), .out_illegal(out_illegal), .out_target(out_target),
    .out_link(out_link), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: counter value per BHT slot, statistics, and last reported result.
  int          bht_m [ENTRIES];
  int          bc_m, mc_m;
  bit          e_valid, e_taken, e_mis, e_ill;
  bit [31:0]   e_target, e_link;

  typedef struct {
    bit        ill, taken, mis;
    bit [31:0] target, link;
  } res_t;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int slot(input bit [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic res_t ref_resolve(input int kind, input int f3, input bit [31:0] rs1,
                                       input bit [31:0] rs2, input bit [31:0] pc,
                                       input bit [31:0] imm, input bit pred);
    res_t r;
    longint u1 = longint'(rs1), u2 = longint'(rs2);
    int     s1 = int'(rs1),     s2 = int'(rs2);
    r.link = pc + 4;
    r.ill = (kind == 3) || (kind == 0 && (f3 == 2 || f3 == 3));
    r.taken = 0; r.mis = 0; r.target = pc + 4;
    if (!r.ill) begin
      if (kind == 0) begin
        case (f3)
          0: r.taken = (u1 == u2);
          1: r.taken = (u1 != u2);
          4: r.taken = (s1 <  s2);
          5: r.taken = (s1 >= s2);
          6: r.taken = (u1 <  u2);
          default: r.taken = (u1 >= u2);
        endcase
        r.mis = (r.taken != pred);
        if (r.taken) r.target = pc + imm;
      end else if (kind == 1) begin
        r.taken = 1; r.mis = !pred; r.target = pc + imm;
      end else begin
        r.taken = 1; r.mis = 1; r.target = (rs1 + imm) - ((rs1 + imm) % 2);
      end
    end
    return r;
  endfunction

  task automatic reset_model();
    foreach (bht_m[i]) bht_m[i] = 1;
    bc_m = 0; mc_m = 0;
    e_valid = 0; e_taken = 0; e_mis = 0; e_ill = 0; e_target = 0; e_link = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"},  out_valid,        e_valid);
    check({tag, ".taken"},  out_taken,        e_taken);
    check({tag, ".mis"},    out_mispredict,   e_mis);
    check({tag, ".ill"},    out_illegal,      e_ill);
    check({tag, ".target"}, out_target,       e_target);
    check({tag, ".link"},   out_link,         e_link);
    check({tag, ".bcnt"},   branch_count,     bc_m);
    check({tag, ".mcnt"},   mispredict_count, mc_m);
  endtask

  // One request: drive at the falling edge, check the same-cycle lookup, then the result.
  task automatic apply(input string tag, input int kind, input int f3, input bit [31:0] rs1,
                       input bit [31:0] rs2, input bit [31:0] pc, input bit [31:0] imm,
                       input bit pred, input bit fl);
    res_t r;
    int   s;
    @(negedge clk);
    res_valid = 1'b1; flush = fl; res_kind = 2'(kind); res_funct3 = 3'(f3);
    res_rs1 = rs1; res_rs2 = rs2; res_pc = pc; res_imm = imm; res_pred_taken = pred;
    pred_pc = pc;
    s = slot(pc);
    #1 check({tag, ".pred_pre"}, pred_taken, bht_m[s] >= 2);
    r = ref_resolve(kind, f3, rs1, rs2, pc, imm, pred);
    e_valid = !fl;
    if (!fl) begin
      e_taken = r.taken; e_mis = r.mis; e_ill = r.ill; e_target = r.target; e_link = r.link;
      if (kind == 0 && !r.ill) begin
        if (r.taken) bht_m[s] = (bht_m[s] < CTR_MAX) ? bht_m[s] + 1 : CTR_MAX;
        else         bht_m[s] = (bht_m[s] > 0) ? bht_m[s] - 1 : 0;
        if (bc_m < CNT_MAX) bc_m++;
      end
      if (r.mis && mc_m < CNT_MAX) mc_m++;
    end
    @(posedge clk);
    #1 res_valid = 1'b0; flush = 1'b0;
    check_outputs(tag);
    check({tag, ".pred_post"}, pred_taken, bht_m[s] >= 2);
  endtask

  task automatic idle(input string tag);
    @(posedge clk);
    #1 e_valid = 0;
    check_outputs(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_model();
    #1;
    check_outputs("reset");
    pred_pc = 32'h40;
    #1 check("reset.pred", pred_taken, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // BEQ equal operands, predicted not-taken.
    apply("beq", 0, 0, 5, 5, 32'h100, 32'h20, 0, 0);
    check("beq.target_lit", out_target, 32'h120);
    check("beq.link_lit",   out_link,   32'h104);
    idle("beq.hold");

    // Signed vs unsigned less-than on the same operands.
    apply("blt",  0, 4, 32'hFFFF_FFFF, 1, 32'h200, 32'h40, 0, 0);
    check("blt.taken_lit", out_taken, 1'b1);
    apply("bltu", 0, 6, 32'hFFFF_FFFF, 1, 32'h204, 32'h40, 0, 0);
    check("bltu.taken_lit", out_taken, 1'b0);
    check("bltu.target_lit", out_target, 32'h208);

    // Train one slot to saturation with taken BNEs.
    for (int i = 0; i < 4; i++) apply("bne_train", 0, 1, 3, 4, 32'h40, 32'h10, 1, 0);
    check("bne.sat_pred", pred_taken, 1'b1);

    apply("jal",  1, 0, 0, 0, 32'h300, 32'hFFFF_FFF0, 0, 0);
    apply("jalr", 2, 0, 32'h1001, 0, 32'h400, 2, 1, 0);
    check("jalr.target_lit", out_target, 32'h1002);

    // Illegal funct3, reserved kind, and a flushed request.
    apply("ill_f3",   0, 2, 1, 1, 32'h40, 32'h8, 1, 0);
    apply("ill_kind", 3, 0, 1, 1, 32'h44, 32'h8, 1, 0);
    apply("flushed",  0, 0, 7, 7, 32'h40, 32'h8, 0, 1);
    idle("flushed.hold");

    // Drive enough JALRs to push the mispredict counter into saturation.
    for (int i = 0; i < 18; i++) apply("mis_sat", 2, 0, 32'h80, 4, 32'h500, 0, 1, 0);
    check("mis_sat.lit", mispredict_count, 4'hF);

    // Randomized traffic with a small PC range so BHT slots alias and train repeatedly.
    for (int i = 0; i < 300; i++) begin
      int        k, f3;
      bit [31:0] a, b, pc, imm, rr;
      k   = $urandom_range(0, 9);
      k   = (k <= 6) ? 0 : k - 6;
      f3  = $urandom_range(0, 7);
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      pc  = 32'($urandom_range(0, 255)) * 4;
      rr  = $urandom;
      imm = {{19{rr[12]}}, rr[12:1], 1'b0};
      apply("rand", k, f3, a, b, pc, imm, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 5) == 0) idle("rand.hold");
    end

    // Asynchronous reset in the middle of a pending request.
    @(negedge clk);
    res_valid = 1'b1; res_kind = 2'b01; res_pc = 32'h600; res_imm = 32'h10; res_pred_taken = 0;
    #2 rst_n = 1'b0;
    reset_model();
    #1;
    check_outputs("midrst");
    pred_pc = 32'h40;
    #1 check("midrst.pred", pred_taken, 1'b0);
    @(negedge clk);
    res_valid = 1'b0;
    rst_n = 1'b1;
    idle("midrst.after");
    apply("post_rst", 0, 5, 9, 2, 32'h40, 32'h20, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
